// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low key matrix one column at a time and reports a single
// debounced key press as a one-cycle KeyValid strobe plus a hex KeyCode.
// Further detection is held off until the accepted key is debounced-released.
//
// Ports:
//   Clk      - system clock
//   Reset    - synchronous, active-high reset
//   Rows     - raw row lines, active-low, asynchronous to Clk
//   Cols     - column drive, active-low, exactly one bit low at all times
//   KeyCode  - hex code of the last accepted key, held until the next accept
//   KeyValid - one-cycle strobe when a press is accepted
//   KeyHeld  - high from acceptance until the release has been debounced
module keypad_scanner #(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Rows,
    output logic [3:0] Cols,
    output logic [3:0] KeyCode,
    output logic       KeyValid,
    output logic       KeyHeld
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        PRESSED = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state;
    logic [3:0]         rowSync1;
    logic [3:0]         rowSync2;
    logic [3:0]         rowHit;
    logic [DWELL_W-1:0] dwellCnt;
    logic [CNT_W-1:0]   debCnt;
    logic [1:0]         colIdx;
    logic [1:0]         nextIdx;
    logic [3:0]         nextCols;
    logic [3:0]         latchedRow;
    logic               latchedHit;
    logic               singleHit;

    // Active-high view of the synchronized rows.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rowHit
            assign rowHit[gi] = ~rowSync2[gi];
        end
    endgenerate

    assign singleHit  = (rowHit != 4'd0) && ((rowHit & (rowHit - 4'd1)) == 4'd0);
    assign latchedHit = |(rowHit & latchedRow);
    assign nextIdx    = colIdx + 2'd1;
    assign nextCols   = ~(4'b0001 << nextIdx);

    function automatic logic [3:0] keyMap(input logic [3:0] rowOneHot, input logic [1:0] col);
        logic [1:0] r;
        logic [3:0] code;
        case (rowOneHot)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        case ({r, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= SCAN;
            rowSync1   <= 4'b1111;
            rowSync2   <= 4'b1111;
            dwellCnt   <= '0;
            debCnt     <= '0;
            colIdx     <= 2'd0;
            Cols       <= 4'b1110;
            latchedRow <= 4'd0;
            KeyCode    <= 4'd0;
            KeyValid   <= 1'b0;
            KeyHeld    <= 1'b0;
        end else begin
            rowSync1 <= Rows;
            rowSync2 <= rowSync1;
            KeyValid <= 1'b0;

            case (state)
                SCAN: begin
                    // Rows are only trusted on the last dwell cycle, once the
                    // synchronizer has caught up with the new column.
                    if (dwellCnt == DWELL_LAST) begin
                        dwellCnt <= '0;
                        if (singleHit) begin
                            latchedRow <= rowHit;
                            debCnt     <= '0;
                            state      <= CONFIRM;
                        end else begin
                            colIdx <= nextIdx;
                            Cols   <= nextCols;
                        end
                    end else begin
                        dwellCnt <= dwellCnt + DWELL_W'(1);
                    end
                end

                CONFIRM: begin
                    if (rowHit == latchedRow) begin
                        if (debCnt == DEB_LAST) begin
                            KeyCode  <= keyMap(latchedRow, colIdx);
                            KeyValid <= 1'b1;
                            KeyHeld  <= 1'b1;
                            debCnt   <= '0;
                            state    <= PRESSED;
                        end else begin
                            debCnt <= debCnt + CNT_W'(1);
                        end
                    end else begin
                        debCnt   <= '0;
                        dwellCnt <= '0;
                        colIdx   <= nextIdx;
                        Cols     <= nextCols;
                        state    <= SCAN;
                    end
                end

                PRESSED: begin
                    // Only the accepted row matters; other keys are ignored.
                    if (!latchedHit) begin
                        debCnt <= '0;
                        state  <= RELEASE;
                    end
                end

                RELEASE: begin
                    if (latchedHit) begin
                        // Bounce: go back to holding without a new strobe.
                        debCnt <= '0;
                        state  <= PRESSED;
                    end else if (debCnt == DEB_LAST) begin
                        debCnt   <= '0;
                        KeyHeld  <= 1'b0;
                        dwellCnt <= '0;
                        colIdx   <= nextIdx;
                        Cols     <= nextCols;
                        state    <= SCAN;
                    end else begin
                        debCnt <= debCnt + CNT_W'(1);
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

endmodule
